// File: rtl/lorenz_solver_seq.sv
// -----------------------------------------------------------------------------
// lorenz_solver_seq
//   Forward-Euler integrator for the Lorenz system
//     x' = sigma*(y - x),  y' = x*(rho - z) - y,  z' = x*y - beta*z
//   in signed fixed point (WIDTH bits, FRAC fraction bits, default 7.20).
//   A single signed multiplier is time-shared over the eight products of a
//   step. One step costs 9 cycles: 8 multiply cycles plus 1 update cycle.
//
//   Optional feature macro: LORENZ_SAT_EN
//     defined   : multiplies and every add/sub saturate to the WIDTH range
//     undefined : multiplies truncate toward -inf, add/sub wrap mod 2^WIDTH
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   start                 run request, only honoured while idle
//   num_steps             number of steps for the run (0 allowed)
//   init_x/y/z            initial state
//   dt, sigma, beta, rho  step size and system coefficients
//   busy                  high from accepted start until done
//   step_valid            1-cycle pulse when x/y/z_out carry a new step
//   done                  1-cycle pulse when the run completes
//   x_out, y_out, z_out   current state
//   step_count            steps completed in the current run
// -----------------------------------------------------------------------------
module lorenz_solver_seq #(
    parameter int WIDTH = 27,
    parameter int FRAC  = 20,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [CNT_W-1:0]        num_steps,
    input  logic signed [WIDTH-1:0] init_x,
    input  logic signed [WIDTH-1:0] init_y,
    input  logic signed [WIDTH-1:0] init_z,
    input  logic signed [WIDTH-1:0] dt,
    input  logic signed [WIDTH-1:0] sigma,
    input  logic signed [WIDTH-1:0] beta,
    input  logic signed [WIDTH-1:0] rho,
    output logic                    busy,
    output logic                    step_valid,
    output logic                    done,
    output logic signed [WIDTH-1:0] x_out,
    output logic signed [WIDTH-1:0] y_out,
    output logic signed [WIDTH-1:0] z_out,
    output logic [CNT_W-1:0]        step_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_MUL,
        S_UPD
    } state_t;

    state_t state, state_n;

    // Run configuration captured on the accepted start.
    logic [CNT_W-1:0]        nsteps_q;
    logic signed [WIDTH-1:0] ix_q, iy_q, iz_q;
    logic signed [WIDTH-1:0] dt_q, sigma_q, beta_q, rho_q;

    // Product slot being computed and the per-step product registers.
    logic [2:0]              idx;
    logic signed [WIDTH-1:0] m [0:7];

    logic signed [WIDTH-1:0] op_a, op_b, mul_res;
    logic signed [2*WIDTH-1:0] prod;

    logic             accept;
    logic [CNT_W-1:0] cnt_inc;
    logic             last_step;

`ifdef LORENZ_SAT_EN
    localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    // One guard bit catches overflow; clamp to the rail on the sum's sign.
    function automatic logic signed [WIDTH-1:0] f_add(
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b
    );
        logic [WIDTH:0] s;
        s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        if (s[WIDTH] != s[WIDTH-1]) return s[WIDTH] ? SMIN : SMAX;
        return s[WIDTH-1:0];
    endfunction

    function automatic logic signed [WIDTH-1:0] f_sub(
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b
    );
        logic [WIDTH:0] s;
        s = {a[WIDTH-1], a} - {b[WIDTH-1], b};
        if (s[WIDTH] != s[WIDTH-1]) return s[WIDTH] ? SMIN : SMAX;
        return s[WIDTH-1:0];
    endfunction
`else
    function automatic logic signed [WIDTH-1:0] f_add(
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b
    );
        return a + b;
    endfunction

    function automatic logic signed [WIDTH-1:0] f_sub(
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b
    );
        return a - b;
    endfunction
`endif

    // -------------------------------------------------------------------------
    // Shared multiplier: operand select per product slot.
    //   0: y*dt   1: x*dt   2: (m0-m1)*sigma   3: rho*dt
    //   4: z*dt   5: x*(m3-m4)   6: x*m0   7: beta*m4
    // -------------------------------------------------------------------------
    always_comb begin
        op_a = x_out;
        op_b = dt_q;
        case (idx)
            3'd0: begin op_a = y_out;              op_b = dt_q;              end
            3'd1: begin op_a = x_out;              op_b = dt_q;              end
            3'd2: begin op_a = f_sub(m[0], m[1]);  op_b = sigma_q;           end
            3'd3: begin op_a = rho_q;              op_b = dt_q;              end
            3'd4: begin op_a = z_out;              op_b = dt_q;              end
            3'd5: begin op_a = x_out;              op_b = f_sub(m[3], m[4]); end
            3'd6: begin op_a = x_out;              op_b = m[0];              end
            3'd7: begin op_a = beta_q;             op_b = m[4];              end
            default: ;
        endcase
    end

    // Sign-extended operands make the low 2*WIDTH bits the signed product.
    assign prod = {{WIDTH{op_a[WIDTH-1]}}, op_a} * {{WIDTH{op_b[WIDTH-1]}}, op_b};

`ifdef LORENZ_SAT_EN
    logic [WIDTH-FRAC:0] prod_hi;
    assign prod_hi = prod[2*WIDTH-1:WIDTH-1+FRAC];

    // In range only when every discarded high bit equals the kept sign bit.
    always_comb begin
        if (&prod_hi || ~|prod_hi) mul_res = prod[WIDTH-1+FRAC:FRAC];
        else                       mul_res = prod[2*WIDTH-1] ? SMIN : SMAX;
    end
`else
    // Keep the true sign, drop the overflow bits; the discarded fraction
    // bits give truncation toward -inf.
    always_comb begin
        mul_res = {prod[2*WIDTH-1], prod[WIDTH-2+FRAC:FRAC]};
    end
`endif

    logic unused_prod_bits;
    assign unused_prod_bits = ^{prod[2*WIDTH-2:WIDTH-1+FRAC], prod[FRAC-1:0]};

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    // A start coinciding with the done pulse is dropped; the following idle
    // cycle accepts again.
    assign accept    = (state == S_IDLE) && start && !done;
    assign cnt_inc   = step_count + 1'b1;
    assign last_step = (cnt_inc == nsteps_q);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (accept) state_n = S_LOAD;
            S_LOAD: state_n = (nsteps_q == '0) ? S_IDLE : S_MUL;
            S_MUL:  if (idx == 3'd7) state_n = S_UPD;
            S_UPD:  state_n = last_step ? S_IDLE : S_MUL;
            default: state_n = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath and registered status outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            busy       <= 1'b0;
            step_valid <= 1'b0;
            done       <= 1'b0;
            x_out      <= '0;
            y_out      <= '0;
            z_out      <= '0;
            step_count <= '0;
            idx        <= '0;
            nsteps_q   <= '0;
            ix_q       <= '0;
            iy_q       <= '0;
            iz_q       <= '0;
            dt_q       <= '0;
            sigma_q    <= '0;
            beta_q     <= '0;
            rho_q      <= '0;
            for (int i = 0; i < 8; i++) m[i] <= '0;
        end else begin
            step_valid <= 1'b0;
            done       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        busy     <= 1'b1;
                        nsteps_q <= num_steps;
                        ix_q     <= init_x;
                        iy_q     <= init_y;
                        iz_q     <= init_z;
                        dt_q     <= dt;
                        sigma_q  <= sigma;
                        beta_q   <= beta;
                        rho_q    <= rho;
                    end
                end
                S_LOAD: begin
                    x_out      <= ix_q;
                    y_out      <= iy_q;
                    z_out      <= iz_q;
                    step_count <= '0;
                    idx        <= '0;
                    if (nsteps_q == '0) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                S_MUL: begin
                    m[idx] <= mul_res;
                    idx    <= idx + 3'd1;   // wraps back to slot 0 after slot 7
                end
                S_UPD: begin
                    // All three state variables commit together from the
                    // products of the previous state.
                    x_out      <= f_add(x_out, m[2]);
                    y_out      <= f_add(y_out, f_sub(m[5], m[0]));
                    z_out      <= f_add(z_out, f_sub(m[6], m[7]));
                    step_count <= cnt_inc;
                    step_valid <= 1'b1;
                    if (last_step) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lorenz_solver_seq.sv
module tb_lorenz_solver_seq;

  localparam int W    = 27;
  localparam int F    = 20;
  localparam int CW   = 16;
  localparam int MAXE = 64;
  localparam int MAXN = 8;
  localparam longint LIM = 64'sd1 <<< (W - 1);

  logic clk = 1'b0;
  logic reset, start;
  logic [CW-1:0] num_steps;
  logic signed [W-1:0] init_x, init_y, init_z, dt, sigma, beta, rho;
  logic busy, step_valid, done;
  logic signed [W-1:0] x_out, y_out, z_out;
  logic [CW-1:0] step_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lorenz_solver_seq #(.WIDTH(W), .FRAC(F), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .num_steps(num_steps),
    .init_x(init_x), .init_y(init_y), .init_z(init_z),
    .dt(dt), .sigma(sigma), .beta(beta), .rho(rho),
    .busy(busy), .step_valid(step_valid), .done(done),
    .x_out(x_out), .y_out(y_out), .z_out(z_out), .step_count(step_count)
  );

  // ---------------- reference arithmetic on plain integers ----------------
  function automatic longint wrapw(input longint v);
    longint t;
    t = v & ((LIM <<< 1) - 1);
    if (t >= LIM) t = t - (LIM <<< 1);
    return t;
  endfunction

  function automatic longint clampw(input longint v);
    if (v > LIM - 1) return LIM - 1;
    if (v < -LIM) return -LIM;
    return v;
  endfunction

  function automatic longint r_add(input longint a, input longint b);
`ifdef LORENZ_SAT_EN
    return clampw(a + b);
`else
    return wrapw(a + b);
`endif
  endfunction

  function automatic longint r_sub(input longint a, input longint b);
`ifdef LORENZ_SAT_EN
    return clampw(a - b);
`else
    return wrapw(a - b);
`endif
  endfunction

  // floor(a*b / 2^F); without saturation keep the product's sign and the
  // low W-1 bits of the scaled value.
  function automatic longint r_mul(input longint a, input longint b);
    longint p, q, t;
    p = a * b;
    q = p >>> F;
`ifdef LORENZ_SAT_EN
    t = clampw(q);
`else
    t = q & (LIM - 1);
    if (p < 0) t = t - LIM;
`endif
    return t;
  endfunction

  longint p_x, p_y, p_z, p_dt, p_sig, p_beta, p_rho;
  longint ex_x [0:MAXN];
  longint ex_y [0:MAXN];
  longint ex_z [0:MAXN];

  task automatic model_run(input int n);
    longint x, y, z, m0, m1, m2, m3, m4, m5, m6, m7;
    x = p_x; y = p_y; z = p_z;
    ex_x[0] = x; ex_y[0] = y; ex_z[0] = z;
    for (int k = 1; k <= n; k++) begin
      m0 = r_mul(y, p_dt);
      m1 = r_mul(x, p_dt);
      m2 = r_mul(r_sub(m0, m1), p_sig);
      m3 = r_mul(p_rho, p_dt);
      m4 = r_mul(z, p_dt);
      m5 = r_mul(x, r_sub(m3, m4));
      m6 = r_mul(x, m0);
      m7 = r_mul(p_beta, m4);
      x = r_add(x, m2);
      y = r_add(y, r_sub(m5, m0));
      z = r_add(z, r_sub(m6, m7));
      ex_x[k] = x; ex_y[k] = y; ex_z[k] = z;
    end
  endtask

  function automatic logic [W-1:0] rnd27();
    logic [31:0] r;
    r = $urandom;
    return r[W-1:0];
  endfunction

  function automatic longint srnd(input int bits);
    logic [31:0] r;
    longint v;
    r = $urandom;
    v = longint'(r) & ((64'sd1 <<< bits) - 1);
    if (v >= (64'sd1 <<< (bits - 1))) v = v - (64'sd1 <<< bits);
    return v;
  endfunction

  task automatic set_cfg(input longint x, input longint y, input longint z, input longint d,
                         input longint sg, input longint bt, input longint rh);
    p_x = x; p_y = y; p_z = z; p_dt = d; p_sig = sg; p_beta = bt; p_rho = rh;
    init_x = x[W-1:0]; init_y = y[W-1:0]; init_z = z[W-1:0];
    dt = d[W-1:0]; sigma = sg[W-1:0]; beta = bt[W-1:0]; rho = rh[W-1:0];
  endtask

  task automatic spec_cfg();
    set_cfg(-64'sd1048576, 64'sh19999, 64'sh1900000, 64'sh1000,
            64'sd10 <<< 20, 64'sh2AAAAA, 64'sd28 <<< 20);
  endtask

  // ---------------- run recorder: index e = edge count after accepting edge E0
  logic ob_sv [0:MAXE];
  logic ob_done [0:MAXE];
  logic ob_busy [0:MAXE];
  logic signed [W-1:0] ob_x [0:MAXE];
  logic signed [W-1:0] ob_y [0:MAXE];
  logic signed [W-1:0] ob_z [0:MAXE];
  logic [CW-1:0] ob_cnt [0:MAXE];

  task automatic do_run(input int n, input int edges, input int pulse_e, input int rst_e);
    @(negedge clk);
    num_steps = n[CW-1:0];
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Configuration must have been captured: scramble the inputs.
    init_x = rnd27(); init_y = rnd27(); init_z = rnd27();
    dt = rnd27(); sigma = rnd27(); beta = rnd27(); rho = rnd27();
    num_steps = 16'hFFFF;
    start = (pulse_e == 1);
    reset = (rst_e == 1);
    for (int e = 1; e <= edges; e++) begin
      @(posedge clk);
      @(negedge clk);
      ob_sv[e] = step_valid; ob_done[e] = done; ob_busy[e] = busy;
      ob_x[e] = x_out; ob_y[e] = y_out; ob_z[e] = z_out; ob_cnt[e] = step_count;
      start = (e + 1 == pulse_e);
      reset = (e + 1 == rst_e);
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; start = 1'b1; num_steps = '0;
    spec_cfg();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); @(negedge clk);
      total++;
      if ({busy, step_valid, done, x_out, y_out, z_out, step_count} !== '0) begin
        bad++;
        $display("FAIL reset_state cyc=%0d got busy=%b sv=%b done=%b x=%0d y=%0d z=%0d cnt=%0d want all 0",
                 c, busy, step_valid, done, x_out, y_out, z_out, step_count);
      end
    end
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    total++;
    if ({busy, done} !== 2'b10) begin
      bad++;
      $display("FAIL reset_release_accept got busy=%b done=%b want busy=1 done=0", busy, done);
    end
    start = 1'b0;
    @(posedge clk); @(negedge clk);
    total++;
    if ({busy, done} !== 2'b01) begin
      bad++;
      $display("FAIL reset_release_done got busy=%b done=%b want busy=0 done=1", busy, done);
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_single_step();
    spec_cfg();
    model_run(1);
    do_run(1, 12, -1, -1);
    total++;
    if (ob_x[10] !== -27'sd1003526) begin
      bad++;
      $display("FAIL single_x got=%0d want=%0d", ob_x[10], -1003526);
    end
    total++;
    if (ob_y[10] !== ex_y[1][W-1:0] || ob_z[10] !== ex_z[1][W-1:0]) begin
      bad++;
      $display("FAIL single_yz got y=%0d z=%0d want y=%0d z=%0d", ob_y[10], ob_z[10], ex_y[1], ex_z[1]);
    end
    total++;
    if ({ob_sv[9], ob_done[9], ob_busy[9], ob_sv[10], ob_done[10], ob_busy[10], ob_cnt[10]}
        !== {3'b001, 3'b110, 16'd1}) begin
      bad++;
      $display("FAIL single_timing got e9=%b%b%b e10=%b%b%b cnt=%0d want e9=001 e10=110 cnt=1",
               ob_sv[9], ob_done[9], ob_busy[9], ob_sv[10], ob_done[10], ob_busy[10], ob_cnt[10]);
    end
  endtask

  task automatic test_multi_step();
    int n, edges, cur;
    logic [2:0] ef;
    n = 3; edges = 31;
    spec_cfg();
    model_run(n);
    do_run(n, edges, -1, -1);
    for (int e = 1; e <= edges; e++) begin
      cur = (e - 1) / 9;
      if (cur > n) cur = n;
      ef = {(e > 1) && ((e - 1) % 9 == 0) && ((e - 1) / 9 <= n), e == 1 + 9 * n, e < 1 + 9 * n};
      total++;
      if ({ob_sv[e], ob_done[e], ob_busy[e]} !== ef) begin
        bad++;
        $display("FAIL multi_ctl e=%0d got sv/done/busy=%b want=%b", e, {ob_sv[e], ob_done[e], ob_busy[e]}, ef);
      end
      total++;
      if (ob_x[e] !== ex_x[cur][W-1:0] || ob_y[e] !== ex_y[cur][W-1:0] ||
          ob_z[e] !== ex_z[cur][W-1:0] || ob_cnt[e] !== cur[CW-1:0]) begin
        bad++;
        $display("FAIL multi_state e=%0d got x=%0d y=%0d z=%0d cnt=%0d want x=%0d y=%0d z=%0d cnt=%0d",
                 e, ob_x[e], ob_y[e], ob_z[e], ob_cnt[e], ex_x[cur], ex_y[cur], ex_z[cur], cur);
      end
    end
  endtask

  task automatic test_zero_steps();
    spec_cfg();
    do_run(0, 4, -1, -1);
    for (int e = 1; e <= 4; e++) begin
      total++;
      if ({ob_sv[e], ob_done[e], ob_busy[e], ob_cnt[e]} !== {1'b0, e == 1, 1'b0, 16'd0} ||
          ob_x[e] !== p_x[W-1:0] || ob_y[e] !== p_y[W-1:0] || ob_z[e] !== p_z[W-1:0]) begin
        bad++;
        $display("FAIL zero_steps e=%0d got sv=%b done=%b busy=%b cnt=%0d x=%0d y=%0d z=%0d want done=%0d x=%0d y=%0d z=%0d",
                 e, ob_sv[e], ob_done[e], ob_busy[e], ob_cnt[e], ob_x[e], ob_y[e], ob_z[e],
                 e == 1, p_x, p_y, p_z);
      end
    end
  endtask

  task automatic test_start_ignored();
    int nsv;
    spec_cfg();
    model_run(3);
    do_run(3, 31, 5, -1);
    nsv = 0;
    for (int e = 1; e <= 31; e++) nsv += int'(ob_sv[e]);
    total++;
    if (nsv != 3 || ob_cnt[28] !== 16'd3 || ob_done[28] !== 1'b1 || ob_x[28] !== ex_x[3][W-1:0]) begin
      bad++;
      $display("FAIL start_ignored got steps=%0d cnt=%0d done28=%b x=%0d want steps=3 cnt=3 done28=1 x=%0d",
               nsv, ob_cnt[28], ob_done[28], ob_x[28], ex_x[3]);
    end
    total++;
    if ({ob_busy[29], ob_busy[30], ob_busy[31], ob_done[29]} !== 4'b0000) begin
      bad++;
      $display("FAIL start_ignored_idle got busy29..31=%b%b%b done29=%b want 0000",
               ob_busy[29], ob_busy[30], ob_busy[31], ob_done[29]);
    end
  endtask

  task automatic test_mid_reset();
    int ndone;
    spec_cfg();
    model_run(1);
    do_run(3, 30, -1, 15);
    ndone = 0;
    for (int e = 1; e <= 30; e++) ndone += int'(ob_done[e]);
    total++;
    if (ndone != 0 || ob_sv[10] !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_done got done_pulses=%0d sv10=%b want 0 and 1", ndone, ob_sv[10]);
    end
    for (int e = 15; e <= 30; e += 5) begin
      total++;
      if ({ob_sv[e], ob_busy[e], ob_x[e], ob_y[e], ob_z[e], ob_cnt[e]} !== '0) begin
        bad++;
        $display("FAIL mid_reset_clear e=%0d got busy=%b x=%0d y=%0d z=%0d cnt=%0d want 0",
                 e, ob_busy[e], ob_x[e], ob_y[e], ob_z[e], ob_cnt[e]);
      end
    end
    spec_cfg();
    do_run(1, 12, -1, -1);
    total++;
    if (ob_x[10] !== ex_x[1][W-1:0] || ob_y[10] !== ex_y[1][W-1:0] || ob_z[10] !== ex_z[1][W-1:0] ||
        ob_done[10] !== 1'b1 || ob_x[1] !== p_x[W-1:0]) begin
      bad++;
      $display("FAIL mid_reset_rerun got x1=%0d x=%0d y=%0d z=%0d done=%b want x1=%0d x=%0d y=%0d z=%0d done=1",
               ob_x[1], ob_x[10], ob_y[10], ob_z[10], ob_done[10], p_x, ex_x[1], ex_y[1], ex_z[1]);
    end
  endtask

  task automatic test_overflow();
    longint want;
    set_cfg(64'sd60 <<< 20, -(64'sd60 <<< 20), 0, 64'sd1 <<< 20, 64'sd10 <<< 20, 0, 0);
    model_run(1);
`ifdef LORENZ_SAT_EN
    want = -64'sd4194304;
`else
    want = -64'sd54525952;
`endif
    do_run(1, 11, -1, -1);
    total++;
    if (ob_x[10] !== want[W-1:0]) begin
      bad++;
      $display("FAIL overflow_x got=%0d want=%0d", ob_x[10], want);
    end
    total++;
    if (ob_y[10] !== ex_y[1][W-1:0] || ob_z[10] !== ex_z[1][W-1:0]) begin
      bad++;
      $display("FAIL overflow_yz got y=%0d z=%0d want y=%0d z=%0d", ob_y[10], ob_z[10], ex_y[1], ex_z[1]);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] ebd;
    spec_cfg();
    @(negedge clk);
    num_steps = '0;
    start = 1'b1;
    @(posedge clk);
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); @(negedge clk);
      ebd = (e == 1 || e == 4) ? 2'b01 : (e == 3) ? 2'b10 : 2'b00;
      total++;
      if ({busy, done} !== ebd || step_valid !== 1'b0) begin
        bad++;
        $display("FAIL back_to_back e=%0d got busy=%b done=%b sv=%b want busy/done=%b sv=0",
                 e, busy, done, step_valid, ebd);
      end
    end
    start = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_random();
    int n, edges, cur;
    logic [2:0] ef;
    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(1, 4);
      edges = 9 * n + 3;
      set_cfg(srnd(W - 1), srnd(W - 1), srnd(W - 1), longint'($urandom_range(0, 65536)),
              srnd(W), srnd(W), srnd(W));
      model_run(n);
      do_run(n, edges, -1, -1);
      for (int e = 1; e <= edges; e++) begin
        cur = (e - 1) / 9;
        if (cur > n) cur = n;
        ef = {(e > 1) && ((e - 1) % 9 == 0) && ((e - 1) / 9 <= n), e == 1 + 9 * n, e < 1 + 9 * n};
        total++;
        if ({ob_sv[e], ob_done[e], ob_busy[e]} !== ef) begin
          bad++;
          $display("FAIL random_ctl run=%0d e=%0d got=%b want=%b", r, e, {ob_sv[e], ob_done[e], ob_busy[e]}, ef);
        end
        total++;
        if (ob_x[e] !== ex_x[cur][W-1:0] || ob_y[e] !== ex_y[cur][W-1:0] ||
            ob_z[e] !== ex_z[cur][W-1:0] || ob_cnt[e] !== cur[CW-1:0]) begin
          bad++;
          $display("FAIL random_state run=%0d e=%0d got x=%0d y=%0d z=%0d cnt=%0d want x=%0d y=%0d z=%0d cnt=%0d",
                   r, e, ob_x[e], ob_y[e], ob_z[e], ob_cnt[e], ex_x[cur], ex_y[cur], ex_z[cur], cur);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_multi_step();
    test_zero_steps();
    test_start_ignored();
    test_mid_reset();
    test_overflow();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
